// File: rtl/nes_line_doubler.sv
// Ping-pong NES scanline buffer that shows each line twice and maps palette indices to 9-bit RGB.
// Read latency 2 cycles, fully pipelined; no backpressure, with overlong lines and late lines flagged by sticky errors.
module nes_line_doubler #(
    parameter int H_ACTIVE = 256,
    parameter int IDX_W    = 6,
    parameter int RGB_W    = 9
) (
    input  logic             pix_clk,
    input  logic             rst,
    input  logic             nes_line_start,
    input  logic             nes_valid,
    input  logic [IDX_W-1:0] nes_index,
    input  logic             rd_en,
    input  logic [7:0]       rd_x,
    input  logic             rd_line_end,
    output logic [RGB_W-1:0] rgb,
    output logic             rgb_valid,
    output logic             line_ready,
    output logic             err_long,
    output logic             err_underrun
);

    localparam int AW = $clog2(H_ACTIVE);
    localparam logic [AW:0] WPTR_FULL = (AW + 1)'(H_ACTIVE);

    // NES 2C02 colours quantised to 3 bits per channel, written as octal R,G,B.
    localparam logic [RGB_W-1:0] PALETTE_INIT [64] = '{
        9'o333, 9'o007, 9'o005, 9'o215, 9'o404, 9'o501, 9'o500, 9'o400,
        9'o210, 9'o030, 9'o030, 9'o020, 9'o022, 9'o000, 9'o000, 9'o000,
        9'o555, 9'o037, 9'o117, 9'o327, 9'o606, 9'o702, 9'o500, 9'o720,
        9'o530, 9'o050, 9'o050, 9'o052, 9'o044, 9'o000, 9'o000, 9'o000,
        9'o777, 9'o157, 9'o347, 9'o437, 9'o737, 9'o724, 9'o732, 9'o752,
        9'o750, 9'o570, 9'o262, 9'o274, 9'o076, 9'o333, 9'o000, 9'o000,
        9'o777, 9'o577, 9'o557, 9'o657, 9'o757, 9'o756, 9'o765, 9'o775,
        9'o763, 9'o673, 9'o575, 9'o576, 9'o077, 9'o767, 9'o000, 9'o000
    };

    logic [IDX_W-1:0] bank0 [H_ACTIVE];
    logic [IDX_W-1:0] bank1 [H_ACTIVE];

    logic          wb;
    logic [AW:0]   wptr;
    logic          wfull;
    logic          rep;

    logic          swap;
    logic          wb_nxt;
    logic          wr_room;
    logic          wr_ok;
    logic          wr_drop;
    logic [AW-1:0] wr_addr;
    logic [AW:0]   wptr_nxt;

    logic             s1_vld;
    logic [IDX_W-1:0] s1_idx;

    // Swap decision uses the registered wfull, so a line completing this cycle waits a full pair.
    always_comb begin
        swap     = rd_line_end & rep & wfull;
        wb_nxt   = wb ^ swap;
        wr_room  = (wptr != WPTR_FULL);
        wr_ok    = nes_valid & (nes_line_start | wr_room);
        wr_drop  = nes_valid & ~nes_line_start & ~wr_room;
        wr_addr  = nes_line_start ? '0 : wptr[AW-1:0];
        wptr_nxt = wptr;
        if (nes_line_start)
            wptr_nxt = {{AW{1'b0}}, nes_valid};
        else if (swap)
            wptr_nxt = '0;
        else if (wr_ok)
            wptr_nxt = wptr + 1'b1;
    end

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            wb           <= 1'b0;
            wptr         <= '0;
            wfull        <= 1'b0;
            rep          <= 1'b0;
            err_long     <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            wb    <= wb_nxt;
            wptr  <= wptr_nxt;
            wfull <= (wptr_nxt == WPTR_FULL);
            if (rd_line_end) begin
                rep <= ~rep;
                if (rep && !wfull)
                    err_underrun <= 1'b1;
            end
            if (wr_drop)
                err_long <= 1'b1;
        end
    end

    // A write coinciding with a swap lands in the bank that becomes the write bank.
    always_ff @(posedge pix_clk) begin
        if (wr_ok && !rst) begin
            if (wb_nxt)
                bank1[wr_addr] <= nes_index;
            else
                bank0[wr_addr] <= nes_index;
        end
    end

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            s1_idx    <= '0;
            rgb       <= '0;
            rgb_valid <= 1'b0;
        end else begin
            s1_vld <= rd_en;
            if (rd_en)
                s1_idx <= wb ? bank0[rd_x] : bank1[rd_x];
            rgb       <= s1_vld ? PALETTE_INIT[s1_idx] : '0;
            rgb_valid <= s1_vld;
        end
    end

    assign line_ready = wfull;

endmodule

// File: tb/tb_nes_line_doubler.sv
// Directed bench for nes_line_doubler: reset, swap, doubling, underrun, overlong and swap-vs-256th-write corner.
module tb_nes_line_doubler;

    logic       pix_clk = 1'b0;
    logic       rst;
    logic       nes_line_start;
    logic       nes_valid;
    logic [5:0] nes_index;
    logic       rd_en;
    logic [7:0] rd_x;
    logic       rd_line_end;
    logic [8:0] rgb;
    logic       rgb_valid;
    logic       line_ready;
    logic       err_long;
    logic       err_underrun;

    int checks = 0;
    int errors = 0;

    logic [8:0] cap    [256];
    logic [8:0] line_a [256];
    int cap_nvld;
    int cap_first;
    int cap_bad_zero;

    localparam logic [8:0] C_0F = 9'h000;
    localparam logic [8:0] C_30 = 9'h1FF;
    localparam logic [8:0] C_16 = 9'b101_000_000;
    localparam logic [8:0] C_12 = 9'b001_001_111;

    nes_line_doubler dut (
        .pix_clk        (pix_clk),
        .rst            (rst),
        .nes_line_start (nes_line_start),
        .nes_valid      (nes_valid),
        .nes_index      (nes_index),
        .rd_en          (rd_en),
        .rd_x           (rd_x),
        .rd_line_end    (rd_line_end),
        .rgb            (rgb),
        .rgb_valid      (rgb_valid),
        .line_ready     (line_ready),
        .err_long       (err_long),
        .err_underrun   (err_underrun)
    );

    always #40 pix_clk = ~pix_clk;

    task automatic tick();
        @(posedge pix_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pixels at columns >= 256 use tail_val; end_last raises rd_line_end on the final write.
    task automatic write_line(input int n, input logic [5:0] val, input logic [5:0] tail_val,
                              input bit ramp, input bit end_last);
        for (int i = 0; i < n; i++) begin
            nes_line_start = (i == 0);
            nes_valid      = 1'b1;
            nes_index      = (i >= 256) ? tail_val : (ramp ? i[5:0] : val);
            rd_line_end    = end_last && (i == n - 1);
            tick();
        end
        nes_line_start = 1'b0;
        nes_valid      = 1'b0;
        nes_index      = '0;
        rd_line_end    = 1'b0;
    endtask

    task automatic line_end();
        rd_line_end = 1'b1;
        tick();
        rd_line_end = 1'b0;
    endtask

    task automatic read_line();
        cap_nvld     = 0;
        cap_first    = -1;
        cap_bad_zero = 0;
        for (int i = 0; i < 260; i++) begin
            rd_en = (i < 256);
            rd_x  = i[7:0];
            tick();
            if (rgb_valid) begin
                if (cap_first < 0) cap_first = i;
                if (cap_nvld < 256) cap[cap_nvld] = rgb;
                cap_nvld++;
            end else if (rgb !== 9'h000) begin
                cap_bad_zero++;
            end
        end
        rd_en = 1'b0;
        rd_x  = '0;
    endtask

    task automatic check_shape(input string tag);
        chk({tag, " latency"}, cap_first, 1);
        chk({tag, " valid_count"}, cap_nvld, 256);
        chk({tag, " idle_rgb_zero"}, cap_bad_zero, 0);
    endtask

    task automatic check_const(input string tag, input logic [8:0] exp);
        int bad;
        bad = 0;
        check_shape(tag);
        for (int i = 0; i < 256; i++)
            if (cap[i] !== exp) bad++;
        chk({tag, " pixels_wrong"}, bad, 0);
    endtask

    task automatic check_same_as_a(input string tag);
        int bad;
        bad = 0;
        check_shape(tag);
        for (int i = 0; i < 256; i++)
            if (cap[i] !== line_a[i]) bad++;
        chk({tag, " pixels_differ"}, bad, 0);
    endtask

    initial begin
        rst = 1'b1; nes_line_start = 1'b0; nes_valid = 1'b0; nes_index = '0;
        rd_en = 1'b0; rd_x = '0; rd_line_end = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset rgb", rgb, 0);
        chk("reset rgb_valid", rgb_valid, 0);
        chk("reset line_ready", line_ready, 0);
        chk("reset err_long", err_long, 0);
        chk("reset err_underrun", err_underrun, 0);

        // Mid-stream reset with a full write line and reads in flight.
        write_line(256, 6'h30, 6'h30, 1'b0, 1'b0);
        chk("pre-rst line_ready", line_ready, 1);
        rd_en = 1'b1; rd_x = 8'd0;
        tick(); tick();
        chk("pre-rst rgb_valid", rgb_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0; rd_en = 1'b0;
        chk("midrst rgb", rgb, 0);
        chk("midrst rgb_valid", rgb_valid, 0);
        chk("midrst line_ready", line_ready, 0);

        // Full line of 0x30, swap after the pair of line ends.
        write_line(256, 6'h30, 6'h30, 1'b0, 1'b0);
        chk("t2 line_ready", line_ready, 1);
        line_end();
        chk("t2 no swap after 1st end", line_ready, 1);
        line_end();
        chk("t2 line_ready cleared by swap", line_ready, 0);
        read_line();
        check_const("t2 white", C_30);
        chk("t2 err_underrun", err_underrun, 0);

        // Ramp line: old line shown on both VGA lines until the pair completes.
        write_line(256, 6'h00, 6'h00, 1'b1, 1'b0);
        read_line();
        check_const("t3 old line 1st", C_30);
        line_end();
        read_line();
        check_const("t3 old line 2nd", C_30);
        line_end();
        read_line();
        check_shape("t3 ramp");
        chk("t3 x15 idx0F", cap[15], C_0F);
        chk("t3 x18 idx12", cap[18], C_12);
        chk("t3 x22 idx16", cap[22], C_16);
        chk("t3 x48 idx30", cap[48], C_30);
        chk("t3 x79 idx0F", cap[79], C_0F);
        chk("t3 x112 idx30", cap[112], C_30);
        for (int i = 0; i < 256; i++) line_a[i] = cap[i];
        line_end();
        read_line();
        check_same_as_a("t3 doubled");

        // Underrun: only 200 pixels when the swap is due.
        write_line(200, 6'h16, 6'h16, 1'b0, 1'b0);
        chk("t4 line_ready", line_ready, 0);
        line_end();
        chk("t4 err_underrun", err_underrun, 1);
        read_line();
        check_same_as_a("t4 repeat old");
        line_end();
        read_line();
        check_same_as_a("t4 repeat old 2");

        // Overlong: 256 x 0x12 then 4 x 0x30 that must be dropped.
        write_line(260, 6'h12, 6'h30, 1'b0, 1'b0);
        chk("t5 err_long", err_long, 1);
        chk("t5 line_ready", line_ready, 1);
        line_end();
        chk("t5 swapped", line_ready, 0);
        read_line();
        check_const("t5 first 256 kept", C_12);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6 rst err_long", err_long, 0);
        chk("t6 rst err_underrun", err_underrun, 0);

        // 256th write in the same cycle as the second line end.
        line_end();
        write_line(256, 6'h16, 6'h16, 1'b0, 1'b1);
        chk("t6 err_underrun", err_underrun, 1);
        chk("t6 line_ready", line_ready, 1);
        read_line();
        check_same_as_a("t6 old ramp kept");
        line_end();
        chk("t6 no swap on 1st end", line_ready, 1);
        line_end();
        chk("t6 swap on 2nd end", line_ready, 0);
        read_line();
        check_const("t6 new line", C_16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
